axi_mem_port: RTL and testbench
===============================

# axi_mem_port

AXI4 slave front-end for the behavioural single-port beat memory in the AXI memory model. It accepts AXI4 read and write bursts from the DUT's memory-side master and drives the memory's beat-addressed port (`addr`, `wr_en`, `rd_en`, `strobe`, `w_data`), capturing `r_data` one cycle after each read strobe. One burst is serviced at a time, with round-robin arbitration between reads and writes.

## Interface
- DATA_WD, 128, AXI data width and memory beat width (bits)
- ADDR_WD, 32, AXI byte-address width
- ID_WD, 4, AXI ID width
- MEM_SIZE, 64, memory size in MiB; addresses at or above MEM_SIZE·2^20 are out of range
- Derived: STRB_WD = DATA_WD/8; ADDR_LSB = log2(STRB_WD)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- awvalid/awready  in/out  1  AW handshake
- awid, awaddr, awlen, awsize, awburst  in  ID_WD, ADDR_WD, 8, 3, 2  write address
- wvalid/wready  in/out  1  W handshake
- wdata, wstrb, wlast  in  DATA_WD, STRB_WD, 1  write data
- bvalid/bready  out/in  1  B handshake
- bid, bresp  out  ID_WD, 2  write response
- arvalid/arready, arid, araddr, arlen, arsize, arburst  in/out, in  (same widths as AW)  read address
- rvalid/rready  out/in  1  R handshake
- rid, rdata, rresp, rlast  out  ID_WD, DATA_WD, 2, 1  read data
- mem_addr  out  ADDR_WD  beat index, byte address >> ADDR_LSB
- mem_wr_en, mem_rd_en  out  1  memory strobes
- mem_strobe, mem_wdata  out  STRB_WD, DATA_WD  byte enables, write data
- mem_rdata  in  DATA_WD  memory read data, valid the cycle after mem_rd_en

## Operation
- States: IDLE, WRITE, WRESP, READ, each a one-hot or encoded register.
- IDLE arbitration: awready = IDLE & awvalid & (prio_w | !arvalid); arready = IDLE & arvalid & (!prio_w | !awvalid). prio_w resets to 1 and toggles on every granted burst.
- AW grant: latch id, addr, len, size, burst, and a beat counter = 0. Go to WRITE.
- WRITE: wready = 1. Each W handshake combinationally drives mem_wr_en = 1, mem_addr = cur>>ADDR_LSB, mem_strobe = wstrb, and mem_wdata = wdata.
  - mem_wr_en is forced to 0 for out-of-range beats.
  - The final beat (counter == len) moves the block to WRESP.
- Address update per beat:
  - INCR: cur += 2^size.
  - FIXED: cur unchanged.
  - WRAP (2'b10) and reserved (2'b11): no memory access. Beats are still consumed and the response is SLVERR.
- bresp = SLVERR (2'b10) if any beat was out-of-range, the burst type is illegal, or wlast ≠ (counter == len) on any beat. Otherwise OKAY. The beat counter is authoritative and wlast never ends a burst.
- WRESP: bvalid = 1 and bid = latched id, held until bready. Go to IDLE.
- AR grant: latch fields, set issue counter and return counter to 0. Go to READ.
- READ issue: mem_rd_en = 1 for the current beat when (buffer occupancy + in-flight) < 2 and the issue counter ≤ len. Out-of-range or illegal-burst beats issue no read.
- READ return:
  - Beat data is mem_rdata in the cycle after mem_rd_en, or zero for a suppressed beat. rresp is per beat.
  - Data enters a 2-entry FIFO. When the FIFO is empty, the returning beat is bypassed straight onto R.
  - rlast = (return counter == len).
  - The final R handshake moves the block to IDLE.
- 4 KiB crossing is not checked; the address simply increments.

## Timing
- Reset outputs: awready = arready = wready = bvalid = rvalid = 0, mem_wr_en = mem_rd_en = 0, bresp = rresp = 0, rlast = 0, mem_addr = 0, state = IDLE, prio_w = 1, FIFO empty.
  - A reset asserted mid-burst abandons the burst. No B or R is issued for it.
- Write burst:
  - AW handshake in cycle t; wready from t+1.
  - With wvalid held high, beat k writes in cycle t+1+k.
  - bvalid in cycle t+len+2.
  - IDLE (awready possible) in the cycle after the B handshake.
- Read burst:
  - AR handshake in cycle t; first mem_rd_en at t+1; first rvalid at t+2.
  - With rready high, one beat per cycle; rlast at t+len+2.
- With rready low, at most 2 beats are buffered and issue stalls. rvalid, rdata, and rlast are held stable until the handshake.
- With AW and AR valid in the same IDLE cycle, exactly one ready is asserted.

## Test plan
- Reset, then AW (addr 0x100, len 3, size 4, INCR, id 5) with 4 full-strobe beats → mem_addr 0x10..0x13 on consecutive cycles; bvalid at t+5 with bid 5, bresp OKAY.
- Reset, then AR (addr 0x100, len 3, INCR), rready high, memory preloaded A,B,C,D → rvalid cycles t+2..t+5 with data A..D; rlast only on D; no bubbles.
- Same read with rready toggling 1,0,0,1,… → no beat lost or duplicated; mem_rd_en stalls when occupancy+in-flight = 2; rdata stable while stalled.
- AW and AR asserted together twice after reset → write granted first, read second; the other ready stays low.
- Write to address MEM_SIZE·2^20, len 0 → mem_wr_en stays 0; bresp SLVERR. Read there → rdata 0, rresp SLVERR, rlast 1.
- Write len 1 with wlast on beat 0 → both beats written; bresp SLVERR. WRAP burst → no memory strobes; SLVERR.

Source files
------------

// File: rtl/axi_mem_port_if.sv
// axi_mem_port_if: AXI4 channel bundle between a bus master and the memory port.
interface axi_mem_port_if #(
    parameter int DATA_WD = 128,
    parameter int ADDR_WD = 32,
    parameter int ID_WD   = 4
);
    logic                 awvalid, awready;
    logic [ID_WD-1:0]     awid;
    logic [ADDR_WD-1:0]   awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 wvalid, wready;
    logic [DATA_WD-1:0]   wdata;
    logic [DATA_WD/8-1:0] wstrb;
    logic                 wlast;
    logic                 bvalid, bready;
    logic [ID_WD-1:0]     bid;
    logic [1:0]           bresp;
    logic                 arvalid, arready;
    logic [ID_WD-1:0]     arid;
    logic [ADDR_WD-1:0]   araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 rvalid, rready;
    logic [ID_WD-1:0]     rid;
    logic [DATA_WD-1:0]   rdata;
    logic [1:0]           rresp;
    logic                 rlast;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );
endinterface

// File: rtl/axi_mem_port.sv
// axi_mem_port: AXI4 slave front-end driving a single-port beat-addressed memory.
// One burst at a time; reads and writes alternate priority when both are pending.
//
// state | meaning
// IDLE  | waiting for AW or AR, round-robin between them
// WRITE | accepting W beats, one memory write per beat
// WRESP | presenting the B response
// READ  | issuing memory reads and returning R beats through a 2-entry FIFO
module axi_mem_port #(
    parameter int DATA_WD  = 128,
    parameter int ADDR_WD  = 32,
    parameter int ID_WD    = 4,
    parameter int MEM_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_mem_port_if.slave        axi,
    output logic [ADDR_WD-1:0]   mem_addr,
    output logic                 mem_wr_en,
    output logic                 mem_rd_en,
    output logic [DATA_WD/8-1:0] mem_strobe,
    output logic [DATA_WD-1:0]   mem_wdata,
    input  logic [DATA_WD-1:0]   mem_rdata
);
    localparam int STRB_WD  = DATA_WD / 8;
    localparam int ADDR_LSB = $clog2(STRB_WD);
    localparam logic [ADDR_WD:0] MEM_LIMIT = (ADDR_WD + 1)'(MEM_SIZE) << 20;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;
    state_t state, state_nxt;

    logic               prio_w;
    logic [ID_WD-1:0]   id_q;
    logic [ADDR_WD-1:0] cur;
    logic [7:0]         len_q;
    logic [2:0]         size_q;
    logic [1:0]         burst_q;
    logic [7:0]         wcnt;
    logic               w_err;
    logic [8:0]         icnt;
    logic [7:0]         rcnt;
    logic               pend, pend_err;
    logic [DATA_WD-1:0] fifo_data [2];
    logic [1:0]         fifo_err;
    logic               fifo_wp, fifo_rp;
    logic [1:0]         fifo_cnt;

    logic               aw_grant, ar_grant, beat_ok, w_beat, w_final, issue;
    logic               r_avail, r_hs, push, pop;
    logic [ADDR_WD-1:0] addr_step;
    logic [DATA_WD-1:0] ret_data, head_data;
    logic               head_err;

    assign aw_grant  = (state == IDLE) && axi.awvalid && (prio_w || !axi.arvalid);
    assign ar_grant  = (state == IDLE) && axi.arvalid && (!prio_w || !axi.awvalid);
    // WRAP and reserved bursts never touch memory.
    assign beat_ok   = ({1'b0, cur} < MEM_LIMIT) && !burst_q[1];
    assign addr_step = (burst_q == 2'b01) ? (ADDR_WD'(1) << size_q) : '0;
    assign w_beat    = (state == WRITE) && axi.wvalid;
    assign w_final   = (wcnt == len_q);
    // Occupancy plus the read in flight may never exceed the FIFO depth.
    assign issue     = (state == READ) && (({1'b0, fifo_cnt} + {2'b0, pend}) < 3'd2)
                       && (icnt <= {1'b0, len_q});
    assign ret_data  = pend_err ? '0 : mem_rdata;
    assign head_data = (fifo_cnt != 2'd0) ? fifo_data[fifo_rp] : ret_data;
    assign head_err  = (fifo_cnt != 2'd0) ? fifo_err[fifo_rp] : pend_err;
    assign r_avail   = (state == READ) && ((fifo_cnt != 2'd0) || pend);
    assign r_hs      = r_avail && axi.rready;
    // A returning beat is bypassed to R only when the FIFO is empty and R is taken.
    assign push      = pend && ((fifo_cnt != 2'd0) || !axi.rready);
    assign pop       = (fifo_cnt != 2'd0) && axi.rready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aw_grant) state_nxt = WRITE;
                     else if (ar_grant) state_nxt = READ;
            WRITE:   if (w_beat && w_final) state_nxt = WRESP;
            WRESP:   if (axi.bready) state_nxt = IDLE;
            READ:    if (r_hs && (rcnt == len_q)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus and memory outputs.
    always_comb begin
        axi.awready = aw_grant;
        axi.arready = ar_grant;
        axi.wready  = (state == WRITE);
        axi.bvalid  = (state == WRESP);
        axi.bid     = id_q;
        axi.bresp   = ((state == WRESP) && w_err) ? RESP_SLVERR : RESP_OKAY;
        axi.rvalid  = r_avail;
        axi.rid     = id_q;
        axi.rdata   = r_avail ? head_data : '0;
        axi.rresp   = (r_avail && head_err) ? RESP_SLVERR : RESP_OKAY;
        axi.rlast   = r_avail && (rcnt == len_q);
        mem_wr_en   = w_beat && beat_ok;
        mem_rd_en   = issue && beat_ok;
        mem_addr    = ((state == WRITE) || (state == READ)) ? (cur >> ADDR_LSB) : '0;
        mem_strobe  = w_beat ? axi.wstrb : '0;
        mem_wdata   = w_beat ? axi.wdata : '0;
    end

    // Burst bookkeeping, read-return FIFO and arbitration priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_w   <= 1'b1;
            id_q     <= '0;
            cur      <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            wcnt     <= '0;
            w_err    <= 1'b0;
            icnt     <= '0;
            rcnt     <= '0;
            pend     <= 1'b0;
            pend_err <= 1'b0;
            fifo_err <= '0;
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            pend     <= issue;
            pend_err <= !beat_ok;
            if (aw_grant) begin
                prio_w  <= !prio_w;
                id_q    <= axi.awid;
                cur     <= axi.awaddr;
                len_q   <= axi.awlen;
                size_q  <= axi.awsize;
                burst_q <= axi.awburst;
                wcnt    <= '0;
                w_err   <= 1'b0;
            end else if (ar_grant) begin
                prio_w   <= !prio_w;
                id_q     <= axi.arid;
                cur      <= axi.araddr;
                len_q    <= axi.arlen;
                size_q   <= axi.arsize;
                burst_q  <= axi.arburst;
                icnt     <= '0;
                rcnt     <= '0;
                fifo_wp  <= 1'b0;
                fifo_rp  <= 1'b0;
                fifo_cnt <= '0;
            end
            if (w_beat) begin
                wcnt  <= wcnt + 8'd1;
                cur   <= cur + addr_step;
                w_err <= w_err || !beat_ok || (axi.wlast != w_final);
            end
            if (issue) begin
                cur  <= cur + addr_step;
                icnt <= icnt + 9'd1;
            end
            if (push) begin
                fifo_data[fifo_wp] <= ret_data;
                fifo_err[fifo_wp]  <= pend_err;
                fifo_wp            <= !fifo_wp;
            end
            if (pop) fifo_rp <= !fifo_rp;
            if (push || pop) fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            if (r_hs) rcnt <= rcnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_axi_mem_port.sv
// tb_axi_mem_port: scoreboard bench for axi_mem_port with a behavioural beat memory.
module tb_axi_mem_port;
    localparam int DW  = 128;
    localparam int AW  = 32;
    localparam int IW  = 4;
    localparam int TMO = 2000;
    localparam logic [31:0] LIMIT = 32'h0400_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_mem_port_if #(.DATA_WD(DW), .ADDR_WD(AW), .ID_WD(IW)) axi ();
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en, mem_rd_en;
    logic [15:0]   mem_strobe;
    logic [DW-1:0] mem_wdata, mem_rdata;

    axi_mem_port #(.DATA_WD(DW), .ADDR_WD(AW), .ID_WD(IW), .MEM_SIZE(64)) dut (
        .clk(clk), .rst_n(rst_n), .axi(axi),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_strobe(mem_strobe), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural memory attached to the DUT's memory port.
    logic [DW-1:0] tmem [int unsigned];
    always @(posedge clk) begin
        if (mem_wr_en) begin
            logic [DW-1:0] v;
            v = tmem.exists(mem_addr) ? tmem[mem_addr] : '0;
            for (int b = 0; b < 16; b++) if (mem_strobe[b]) v[b*8 +: 8] = mem_wdata[b*8 +: 8];
            tmem[mem_addr] = v;
        end
        if (mem_rd_en) mem_rdata <= tmem.exists(mem_addr) ? tmem[mem_addr] : '0;
    end

    // Reference model state and expectation queues.
    logic [DW-1:0] ref_mem [int unsigned];
    logic [31:0]   exp_wa[$];
    logic [15:0]   exp_ws[$];
    logic [DW-1:0] exp_wd[$];
    logic [31:0]   exp_ra[$];
    logic [DW-1:0] exp_rd[$];
    logic [6:0]    exp_rx[$];   // {rid, rresp, rlast}
    logic [5:0]    exp_b[$];    // {bid, bresp}
    bit            glog[$];     // 1 = write grant, 0 = read grant
    logic [DW-1:0] wd [256];
    logic [15:0]   ws [256];
    logic          wl [256];

    function automatic logic [31:0] beat_addr(logic [31:0] a, logic [2:0] sz, logic [1:0] bt, int k);
        return (bt == 2'b01) ? a + (32'(k) << sz) : a;
    endfunction

    function automatic logic [DW-1:0] ref_rd(logic [31:0] i);
        return ref_mem.exists(i) ? ref_mem[i] : '0;
    endfunction

    task automatic model_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] sz, input logic [1:0] bt, input int bad, input bit full);
        bit err = 0;
        for (int k = 0; k <= len; k++) begin
            logic [31:0] a;
            logic [DW-1:0] v;
            wd[k] = {$urandom, $urandom, $urandom, $urandom};
            ws[k] = full ? 16'hFFFF : 16'($urandom);
            wl[k] = (k == len) ^ (k == bad);
            a = beat_addr(addr, sz, bt, k);
            if (bt[1] || a >= LIMIT) err = 1;
            else begin
                exp_wa.push_back(a >> 4);
                exp_ws.push_back(ws[k]);
                exp_wd.push_back(wd[k]);
                v = ref_rd(a >> 4);
                for (int b = 0; b < 16; b++) if (ws[k][b]) v[b*8 +: 8] = wd[k][b*8 +: 8];
                ref_mem[a >> 4] = v;
            end
            if (k == bad) err = 1;
        end
        exp_b.push_back({id, err ? 2'b10 : 2'b00});
    endtask

    task automatic model_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [2:0] sz, input logic [1:0] bt);
        for (int k = 0; k <= len; k++) begin
            logic [31:0] a;
            a = beat_addr(addr, sz, bt, k);
            if (!bt[1] && a < LIMIT) begin
                exp_ra.push_back(a >> 4);
                exp_rd.push_back(ref_rd(a >> 4));
                exp_rx.push_back({id, 2'b00, k == len});
            end else begin
                exp_rd.push_back('0);
                exp_rx.push_back({id, 2'b10, k == len});
            end
        end
    endtask

    // Monitor / scoreboard.
    int  wr_cnt = 0, rd_cnt = 0, b_cnt = 0, r_cnt = 0;
    int  last_wr_cyc = -1, b_rise_cyc = -1, r_rise_cyc = -1, r_hs_cyc = -1;
    bit  bv_prev = 0, rv_prev = 0, rr_prev = 0, chk_occ = 0;
    logic [DW-1:0] rd_prev;
    logic          rl_prev;
    always @(negedge clk) begin
        if (rst_n) begin
            if (axi.awready && axi.arready) chk(0, "both ready", 2'b11, 2'b01);
            if (axi.awvalid && axi.awready) glog.push_back(1'b1);
            if (axi.arvalid && axi.arready) glog.push_back(1'b0);
            if (mem_wr_en) begin
                if (exp_wa.size() == 0) chk(0, "unexpected mem write", mem_addr, 0);
                else begin
                    chk(mem_addr == exp_wa.pop_front(), "mem_wr addr", mem_addr, 0);
                    chk(mem_strobe == exp_ws.pop_front(), "mem_wr strobe", mem_strobe, 0);
                    chk(mem_wdata == exp_wd.pop_front(), "mem_wr data", mem_wdata, 0);
                end
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (mem_rd_en) begin
                if (exp_ra.size() == 0) chk(0, "unexpected mem read", mem_addr, 0);
                else begin
                    logic [31:0] ea;
                    ea = exp_ra.pop_front();
                    chk(mem_addr == ea, "mem_rd addr", mem_addr, ea);
                end
                rd_cnt++;
            end
            if (chk_occ) chk(rd_cnt - r_cnt <= 2, "read occupancy", rd_cnt - r_cnt, 2);
            if (axi.bvalid && !bv_prev) b_rise_cyc = cyc;
            bv_prev = axi.bvalid;
            if (axi.bvalid && axi.bready) begin
                if (exp_b.size() == 0) chk(0, "unexpected B", {axi.bid, axi.bresp}, 0);
                else begin
                    logic [5:0] eb;
                    eb = exp_b.pop_front();
                    chk({axi.bid, axi.bresp} == eb, "B id/resp", {axi.bid, axi.bresp}, eb);
                end
                b_cnt++;
            end
            if (rv_prev && !rr_prev)
                chk(axi.rvalid && axi.rdata == rd_prev && axi.rlast == rl_prev, "R stable while stalled",
                    {axi.rvalid, axi.rlast, axi.rdata}, {1'b1, rl_prev, rd_prev});
            if (axi.rvalid && !rv_prev) r_rise_cyc = cyc;
            rv_prev = axi.rvalid; rr_prev = axi.rready; rd_prev = axi.rdata; rl_prev = axi.rlast;
            if (axi.rvalid && axi.rready) begin
                if (exp_rd.size() == 0) chk(0, "unexpected R", axi.rdata, 0);
                else begin
                    logic [DW-1:0] ed;
                    logic [6:0] ex;
                    ed = exp_rd.pop_front();
                    ex = exp_rx.pop_front();
                    chk(axi.rdata == ed, "R data", axi.rdata, ed);
                    chk({axi.rid, axi.rresp, axi.rlast} == ex, "R id/resp/last", {axi.rid, axi.rresp, axi.rlast}, ex);
                end
                r_cnt++;
                r_hs_cyc = cyc;
            end
        end else begin
            bv_prev = 0; rv_prev = 0; rr_prev = 1;
        end
    end

    // R / B ready drivers.
    int rmode = 0, bmode = 0, rph = 0;
    bit [3:0] rpat = 4'b1001;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: axi.rready = 1'b1;
            1: begin axi.rready = rpat[rph]; rph = (rph + 1) % 4; end
            default: axi.rready = 1'($urandom_range(0, 1));
        endcase
        axi.bready = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [31:0] a, input int len, input logic [2:0] sz, input logic [1:0] bt);
        axi.awid = id; axi.awaddr = a; axi.awlen = 8'(len); axi.awsize = sz; axi.awburst = bt;
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [31:0] a, input int len, input logic [2:0] sz, input logic [1:0] bt);
        axi.arid = id; axi.araddr = a; axi.arlen = 8'(len); axi.arsize = sz; axi.arburst = bt;
    endtask

    task automatic wait_aw(output int t);
        int n = 0;
        do begin @(negedge clk); n++; end while (!axi.awready && n < TMO);
        if (!axi.awready) chk(0, "AW handshake timeout", 0, 1);
        t = cyc;
        @(posedge clk); #1;
    endtask

    task automatic wait_ar(output int t);
        int n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && n < TMO);
        if (!axi.arready) chk(0, "AR handshake timeout", 0, 1);
        t = cyc;
        @(posedge clk); #1;
    endtask

    task automatic send_w(input int len);
        for (int k = 0; k <= len; k++) begin
            int n = 0;
            axi.wvalid = 1'b1; axi.wdata = wd[k]; axi.wstrb = ws[k]; axi.wlast = wl[k];
            do begin @(negedge clk); n++; end while (!axi.wready && n < TMO);
            if (!axi.wready) chk(0, "W handshake timeout", 0, 1);
            @(posedge clk); #1;
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
    endtask

    task automatic wait_cnt_b(input int target);
        int n = 0;
        while (b_cnt < target && n < TMO) begin @(posedge clk); #1; n++; end
        if (b_cnt < target) chk(0, "B timeout", b_cnt, target);
    endtask

    task automatic wait_cnt_r(input int target);
        int n = 0;
        while (r_cnt < target && n < TMO) begin @(posedge clk); #1; n++; end
        if (r_cnt < target) chk(0, "R timeout", r_cnt, target);
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] a, input int len, input logic [2:0] sz,
                               input logic [1:0] bt, input int bad, input bit full, output int t);
        int tb0;
        tb0 = b_cnt;
        model_write(id, a, len, sz, bt, bad, full);
        set_aw(id, a, len, sz, bt);
        axi.awvalid = 1'b1;
        wait_aw(t);
        axi.awvalid = 1'b0;
        send_w(len);
        wait_cnt_b(tb0 + 1);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] a, input int len, input logic [2:0] sz,
                              input logic [1:0] bt, output int t);
        int tr0;
        tr0 = r_cnt;
        model_read(id, a, len, sz, bt);
        set_ar(id, a, len, sz, bt);
        axi.arvalid = 1'b1;
        wait_ar(t);
        axi.arvalid = 1'b0;
        wait_cnt_r(tr0 + len + 1);
    endtask

    initial begin
        int t, w0, r0, g0, tb0, tr0, n;
        axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0; axi.wlast = 0;
        axi.wdata = '0; axi.wstrb = '0;
        set_aw(0, 0, 0, 0, 0);
        set_ar(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, mem_wr_en, mem_rd_en,
             axi.bresp, axi.rresp, axi.rlast} == '0, "reset outputs",
            {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, mem_wr_en, mem_rd_en,
             axi.bresp, axi.rresp, axi.rlast}, 0);
        chk(mem_addr == '0, "reset mem_addr", mem_addr, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // INCR write, 4 beats of 16 bytes from 0x100.
        w0 = wr_cnt;
        write_burst(5, 32'h100, 3, 4, 2'b01, -1, 1, t);
        chk(last_wr_cyc == t + 4, "write last beat cycle", last_wr_cyc, t + 4);
        chk(wr_cnt - w0 == 4, "write beat count", wr_cnt - w0, 4);
        chk(b_rise_cyc == t + 5, "bvalid cycle", b_rise_cyc, t + 5);

        // Read the same beats back with rready high.
        do_reset();
        r0 = r_cnt;
        read_burst(6, 32'h100, 3, 4, 2'b01, t);
        chk(r_rise_cyc == t + 2, "first rvalid cycle", r_rise_cyc, t + 2);
        chk(r_hs_cyc == t + 5, "rlast cycle", r_hs_cyc, t + 5);
        chk(r_cnt - r0 == 4, "read beat count", r_cnt - r0, 4);

        // Same read with a stalling R channel.
        rmode = 1; chk_occ = 1;
        read_burst(7, 32'h100, 3, 4, 2'b01, t);
        repeat (2) @(posedge clk);
        #1 chk_occ = 0; rmode = 0;

        // Simultaneous AW and AR twice after reset: write, then read, then write.
        do_reset();
        g0 = glog.size();
        tb0 = b_cnt;
        tr0 = r_cnt;
        model_write(1, 32'h200, 0, 4, 2'b01, -1, 1);
        model_read(2, 32'h100, 0, 4, 2'b01);
        set_aw(1, 32'h200, 0, 4, 2'b01);
        set_ar(2, 32'h100, 0, 4, 2'b01);
        axi.awvalid = 1'b1; axi.arvalid = 1'b1;
        @(negedge clk);
        chk(axi.awready && !axi.arready, "first arbitration", {axi.awready, axi.arready}, 2'b10);
        @(posedge clk); #1;
        set_aw(3, 32'h300, 0, 4, 2'b01);
        send_w(0);
        wait_cnt_b(tb0 + 1);
        model_write(3, 32'h300, 0, 4, 2'b01, -1, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && !axi.awready && n < TMO);
        chk(axi.arready && !axi.awready, "second arbitration", {axi.awready, axi.arready}, 2'b01);
        @(posedge clk); #1 axi.arvalid = 1'b0;
        wait_cnt_r(tr0 + 1);
        wait_aw(t);
        axi.awvalid = 1'b0;
        send_w(0);
        wait_cnt_b(tb0 + 2);
        chk(glog.size() - g0 == 3 && glog[g0] && !glog[g0 + 1] && glog[g0 + 2], "grant order",
            {glog.size() - g0 >= 3 ? glog[g0] : 1'b0, glog.size() - g0 >= 3 ? glog[g0 + 1] : 1'b0}, 2'b10);

        // Out-of-range, early wlast and WRAP cases.
        w0 = wr_cnt;
        write_burst(9, LIMIT, 0, 4, 2'b01, -1, 1, t);
        chk(wr_cnt == w0, "no write out of range", wr_cnt - w0, 0);
        read_burst(10, LIMIT, 0, 4, 2'b01, t);
        w0 = wr_cnt;
        write_burst(11, 32'h500, 1, 4, 2'b01, 0, 1, t);
        chk(wr_cnt - w0 == 2, "early wlast beats written", wr_cnt - w0, 2);
        w0 = wr_cnt;
        write_burst(12, 32'h400, 3, 4, 2'b10, -1, 1, t);
        chk(wr_cnt == w0, "no write for WRAP", wr_cnt - w0, 0);
        r0 = rd_cnt;
        read_burst(13, 32'h500, 3, 4, 2'b10, t);
        chk(rd_cnt == r0, "no read for WRAP", rd_cnt - r0, 0);

        // Randomised bursts with random B and R back-pressure.
        bmode = 1; rmode = 2;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            logic [1:0]  bt;
            int len, bad;
            a   = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 32'h7F0)) : LIMIT - 32'($urandom_range(0, 64));
            len = $urandom_range(0, 7);
            bt  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : -1;
            if ($urandom_range(0, 1) == 1)
                write_burst(4'($urandom), a, len, 3'($urandom_range(0, 4)), bt, bad, 1'($urandom_range(0, 1)), t);
            else
                read_burst(4'($urandom), a, len, 3'($urandom_range(0, 4)), bt, t);
        end
        repeat (10) @(posedge clk);
        chk(exp_wa.size() + exp_ra.size() + exp_rd.size() + exp_b.size() == 0, "scoreboard drained",
            exp_wa.size() + exp_ra.size() + exp_rd.size() + exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
